// File: rtl/trb_pkg.sv
// trb_pkg: shared constants and types for the turbo output byte-to-line packer
package trb_pkg;
  localparam int TRB_FRAME_BYTES = 128;
  localparam int TRB_LINE_BYTES = 64;
  typedef enum logic [1:0] {IDLE, FILL, DROP} trb_pack_st_e;
  typedef struct packed {
    logic [511:0] data;
    logic last;
  } trb_line_t;
endpackage

// File: rtl/trb_line_buf.sv
// trb_line_buf: two-slot line FIFO filled byte-by-byte in place
// Ports: clk, rst_n (async active-low); wr_en/wr_pos/wr_byte write one byte of the
// fill slot; push closes the fill slot with push_last; pop retires head; count/full status.
module trb_line_buf
  import trb_pkg::*;
#(
  parameter int LINE_BYTES = TRB_LINE_BYTES,
  parameter int PW = $clog2(LINE_BYTES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wr_en,
  input  logic [PW-1:0] wr_pos,
  input  logic [7:0] wr_byte,
  input  logic push,
  input  logic push_last,
  input  logic pop,
  output trb_line_t head,
  output logic [1:0] count,
  output logic full
);
  trb_line_t slots [2];
  logic wp, rp;
  // Writing byte 0 clears the slot, so a line closed early by eop is zero-padded.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      slots <= '{default: '0};
      wp <= 1'b0;
      rp <= 1'b0;
      count <= 2'd0;
    end else begin
      if (wr_en && wr_pos == '0) slots[wp].data <= 512'(wr_byte);
      else if (wr_en) slots[wp].data[9'({wr_pos, 3'b000}) +: 8] <= wr_byte;
      if (push) begin
        slots[wp].last <= push_last;
        wp <= ~wp;
      end
      if (pop) rp <= ~rp;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  assign head = slots[rp];
  assign full = count == 2'd2;
endmodule

// File: rtl/trb_out_pack.sv
// trb_out_pack: packs 8-bit framed byte stream into tagged cache lines
// Ports: clk, rst_n (async active-low); st_* byte input with ready; line_* output
// stream with last; frame_cnt_out counts accepted last lines; err_sop_out/err_len_out
// sticky framing errors, built only when TRB_PACK_ERR_CHK_EN is defined (else tied 0).
module trb_out_pack
  import trb_pkg::*;
#(
  parameter int FRAME_BYTES = TRB_FRAME_BYTES,
  parameter int LINE_BYTES = TRB_LINE_BYTES,
  parameter int FCNT_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [7:0] st_data_in,
  input  logic st_valid_in,
  input  logic st_sop_in,
  input  logic st_eop_in,
  output logic st_ready_out,
  output logic [8*LINE_BYTES-1:0] line_data_out,
  output logic line_valid_out,
  output logic line_last_out,
  input  logic line_ready_in,
  output logic [FCNT_W-1:0] frame_cnt_out,
  output logic err_sop_out,
  output logic err_len_out
);
  localparam int CW = $clog2(FRAME_BYTES) + 1;
  localparam int PW = $clog2(LINE_BYTES);
  trb_pack_st_e st;
  trb_line_t head;
  logic run, full, xfer, take, close, last, full_frame, pop;
  logic [1:0] used;
  logic [CW-1:0] cnt, base, nxt;
  logic [PW-1:0] pos;
  // An IDLE byte with sop is treated as a FILL byte at counter 0.
  always_comb begin
    xfer = st_valid_in && st_ready_out;
    take = xfer && (st == FILL || (st == IDLE && st_sop_in));
    base = st == FILL ? cnt : '0;
    nxt = base + 1'b1;
    pos = PW'(base % LINE_BYTES);
    full_frame = nxt == CW'(FRAME_BYTES);
    last = st_eop_in || full_frame;
    close = take && (pos == PW'(LINE_BYTES - 1) || st_eop_in);
    pop = line_valid_out && line_ready_in;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= IDLE;
      cnt <= '0;
      run <= 1'b0;
      frame_cnt_out <= '0;
    end else begin
      run <= 1'b1;
      if (pop && head.last) frame_cnt_out <= frame_cnt_out + 1'b1;
      if (take) begin
        st <= st_eop_in ? IDLE : full_frame ? DROP : FILL;
        cnt <= last ? '0 : nxt;
      end else if (xfer && st == DROP && st_eop_in) st <= IDLE;
    end
`ifdef TRB_PACK_ERR_CHK_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      err_sop_out <= 1'b0;
      err_len_out <= 1'b0;
    end else begin
      if (xfer && (st == IDLE ? !st_sop_in : st == FILL && st_sop_in)) err_sop_out <= 1'b1;
      if (take && st_eop_in != full_frame) err_len_out <= 1'b1;
    end
`else
  assign err_sop_out = 1'b0;
  assign err_len_out = 1'b0;
`endif
  trb_line_buf #(.LINE_BYTES(LINE_BYTES)) u_buf (
    .clk(clk),
    .rst_n(rst_n),
    .wr_en(take),
    .wr_pos(pos),
    .wr_byte(st_data_in),
    .push(close),
    .push_last(last),
    .pop(pop),
    .head(head),
    .count(used),
    .full(full)
  );
  assign st_ready_out = run && !full;
  assign line_valid_out = used != 2'd0;
  assign line_data_out = head.data[8*LINE_BYTES-1:0];
  assign line_last_out = head.last;
endmodule

// File: tb/tb_trb_out_pack.sv
// tb_trb_out_pack: scoreboard bench for the byte-to-line packer
module tb_trb_out_pack;
  localparam int FB = 128;
  localparam int LB = 64;
`ifdef TRB_PACK_ERR_CHK_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif
  typedef struct packed {
    logic [511:0] data;
    logic last;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [7:0] st_data_in = '0;
  logic st_valid_in = 1'b0, st_sop_in = 1'b0, st_eop_in = 1'b0, line_ready_in = 1'b1;
  logic st_ready_out, line_valid_out, line_last_out, err_sop_out, err_len_out;
  logic [511:0] line_data_out;
  logic [15:0] frame_cnt_out;
  exp_t sb[$];
  exp_t m;
  int errors = 0, checks = 0, exp_fcnt = 0;

  always #5 clk = ~clk;

  trb_out_pack dut (
    .clk(clk),
    .rst_n(rst_n),
    .st_data_in(st_data_in),
    .st_valid_in(st_valid_in),
    .st_sop_in(st_sop_in),
    .st_eop_in(st_eop_in),
    .st_ready_out(st_ready_out),
    .line_data_out(line_data_out),
    .line_valid_out(line_valid_out),
    .line_last_out(line_last_out),
    .line_ready_in(line_ready_in),
    .frame_cnt_out(frame_cnt_out),
    .err_sop_out(err_sop_out),
    .err_len_out(err_len_out)
  );

  task automatic send_byte(input logic [7:0] d, input logic s, input logic e);
    int n = 0;
    st_data_in = d;
    st_sop_in = s;
    st_eop_in = e;
    st_valid_in = 1'b1;
    while (!st_ready_out && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL byte_timeout: ready=%0b after %0d cycles, required 1", st_ready_out, n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int len, input int eop_at, input int seed);
    int stored, nl;
    logic complete;
    exp_t e;
    complete = eop_at >= 0 || len >= FB;
    stored = (eop_at >= 0 && eop_at < FB) ? eop_at + 1 : (len < FB ? len : FB);
    nl = complete ? (stored + LB - 1) / LB : stored / LB;
    for (int l = 0; l < nl; l++) begin
      e = '0;
      for (int k = 0; k < LB; k++)
        if (l * LB + k < stored) e.data[8*k +: 8] = 8'(seed + l * LB + k);
      e.last = complete && l == nl - 1;
      if (e.last) exp_fcnt++;
      sb.push_back(e);
    end
    for (int i = 0; i < len; i++) send_byte(8'(seed + i), i == 0, i == eop_at);
    st_valid_in = 1'b0;
    st_sop_in = 1'b0;
    st_eop_in = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d lines outstanding, required 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_fcnt(input string name);
    checks++;
    if (frame_cnt_out !== 16'(exp_fcnt)) begin
      errors++;
      $display("FAIL %s_fcnt: got %0d required %0d", name, frame_cnt_out, exp_fcnt);
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({st_ready_out, line_valid_out, line_last_out, err_sop_out, err_len_out} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b required 00000", {st_ready_out, line_valid_out, line_last_out, err_sop_out, err_len_out});
    end
    checks++;
    if (frame_cnt_out !== 16'd0 || line_data_out !== 512'd0) begin
      errors++;
      $display("FAIL reset_data: got cnt=%0d data=%h required zeros", frame_cnt_out, line_data_out);
    end
    #2 rst_n = 1'b1;
    #1;
    checks++;
    if (st_ready_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_early: got %b required 0", st_ready_out);
    end
    @(posedge clk);
    #1;
    checks++;
    if (st_ready_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_rise: got %b required 1", st_ready_out);
    end
  endtask

  task automatic test_basic();
    time t0;
    t0 = $time;
    send_frame(FB, FB - 1, 0);
    checks++;
    if (($time - t0) / 10 != FB) begin
      errors++;
      $display("FAIL basic_rate: took %0d cycles required %0d", ($time - t0) / 10, FB);
    end
    wait_drain();
    check_fcnt("basic");
    checks++;
    if (err_sop_out !== 1'b0 || err_len_out !== 1'b0) begin
      errors++;
      $display("FAIL basic_err: got sop=%b len=%b required 0 0", err_sop_out, err_len_out);
    end
  endtask

  task automatic test_back_to_back();
    line_ready_in = 1'b0;
    fork
      begin
        repeat (200) @(posedge clk);
        #1 line_ready_in = 1'b1;
      end
    join_none
    send_frame(FB, FB - 1, 8'h40);
    checks++;
    if (st_ready_out !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ready_drop: got %b required 0", st_ready_out);
    end
    checks++;
    if (line_valid_out !== 1'b1 || line_last_out !== 1'b0 || line_data_out[7:0] !== 8'h40) begin
      errors++;
      $display("FAIL b2b_hold: got valid=%b last=%b byte0=%h required 1 0 40", line_valid_out, line_last_out, line_data_out[7:0]);
    end
    for (int f = 1; f < 4; f++) send_frame(FB, FB - 1, f * 37);
    wait_drain();
    check_fcnt("b2b");
  endtask

  task automatic test_no_sop();
    for (int i = 0; i < 5; i++) send_byte(8'(200 + i), 1'b0, 1'b0);
    st_valid_in = 1'b0;
    send_frame(FB, FB - 1, 11);
    wait_drain();
    check_fcnt("nosop");
    checks++;
    if (err_sop_out !== ERR || err_len_out !== 1'b0) begin
      errors++;
      $display("FAIL nosop_err: got sop=%b len=%b required %b 0", err_sop_out, err_len_out, ERR);
    end
  endtask

  task automatic test_overlong();
    send_frame(FB + 2, FB + 1, 5);
    checks++;
    if (err_len_out !== ERR) begin
      errors++;
      $display("FAIL long_err: got %b required %b", err_len_out, ERR);
    end
    send_frame(FB, FB - 1, 77);
    wait_drain();
    check_fcnt("long");
  endtask

  task automatic test_mid_reset();
    send_frame(70, -1, 33);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL midrst_line0: %0d lines outstanding, required 0", sb.size());
    end
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    exp_fcnt = 0;
    checks++;
    if ({st_ready_out, line_valid_out, line_last_out, err_sop_out, err_len_out} !== 5'b0 || frame_cnt_out !== 16'd0 || line_data_out !== 512'd0) begin
      errors++;
      $display("FAIL midrst_zero: got flags=%b cnt=%0d data=%h required zeros", {st_ready_out, line_valid_out, line_last_out, err_sop_out, err_len_out}, frame_cnt_out, line_data_out);
    end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    checks++;
    if (st_ready_out !== 1'b0) begin
      errors++;
      $display("FAIL midrst_ready_early: got %b required 0", st_ready_out);
    end
    @(posedge clk);
    #1;
    checks++;
    if (st_ready_out !== 1'b1) begin
      errors++;
      $display("FAIL midrst_ready_rise: got %b required 1", st_ready_out);
    end
    send_frame(FB, FB - 1, 99);
    wait_drain();
    check_fcnt("midrst");
  endtask

  task automatic test_eop_short();
    send_frame(100, 99, 150);
    wait_drain();
    check_fcnt("short");
    checks++;
    if (err_len_out !== ERR) begin
      errors++;
      $display("FAIL short_err: got %b required %b", err_len_out, ERR);
    end
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (rst_n && line_valid_out && line_ready_in) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_extra: got unexpected line last=%b required none", line_last_out);
          end else begin
            m = sb.pop_front();
            if (line_data_out !== m.data || line_last_out !== m.last) begin
              errors++;
              $display("FAIL sb_line: got last=%b data=%h required last=%b data=%h", line_last_out, line_data_out, m.last, m.data);
            end
          end
        end
      end
    join_none
    test_reset();
    test_basic();
    test_back_to_back();
    test_no_sop();
    test_overlong();
    test_mid_reset();
    test_eop_short();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
